// File: rtl/prefix_if.sv
// Descriptor-in / byte-out handshake bundle for the x86 prefix encoder.
// The slave modport is the encoder's view; the master modport is the producer/consumer side.
interface prefix_if;
    localparam int unsigned SEG_W  = 6;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;

    logic              in_valid;
    logic              in_ready;
    logic              in_is_rep;
    logic [SEG_W-1:0]  in_seg_override;
    logic              in_is_opsize;
    logic [BYTE_W-1:0] in_opcode;
    logic              out_valid;
    logic              out_ready;
    logic [BYTE_W-1:0] out_byte;
    logic              out_last;
    logic [CNT_W-1:0]  out_pfx_count;

    modport slave (
        input  in_valid, in_is_rep, in_seg_override, in_is_opsize, in_opcode, out_ready,
        output in_ready, out_valid, out_byte, out_last, out_pfx_count
    );

    modport master (
        output in_valid, in_is_rep, in_seg_override, in_is_opsize, in_opcode, out_ready,
        input  in_ready, out_valid, out_byte, out_last, out_pfx_count
    );
endinterface

// File: rtl/prefix_encoder.sv
// Serializes one decoded instruction descriptor into its canonical x86 byte stream:
// REP (F3), one segment override, operand-size (66), then the opcode.
module prefix_encoder (
    input  logic     clk,
    input  logic     rst_n,
    prefix_if.slave  bus
);
    localparam int unsigned SEG_W  = 6;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [2:0] {IDLE, REP, SEG, OPSZ, OPC} state_t;

    typedef struct packed {
        logic              rep;
        logic [SEG_W-1:0]  seg;
        logic              opsz;
        logic [BYTE_W-1:0] opcode;
    } desc_t;

    state_t            state_q, state_d;
    desc_t             desc_q, desc_d, in_desc;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, advance;

    // Next applicable state after cur, skipping prefixes the descriptor lacks.
    function automatic state_t next_state(input state_t cur, input desc_t d);
        state_t n;
        n = IDLE;
        case (cur)
            IDLE:    n = d.rep ? REP : (|d.seg) ? SEG : d.opsz ? OPSZ : OPC;
            REP:     n = (|d.seg) ? SEG : d.opsz ? OPSZ : OPC;
            SEG:     n = d.opsz ? OPSZ : OPC;
            OPSZ:    n = OPC;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    // Lowest set bit of a multi-hot segment override wins.
    function automatic logic [BYTE_W-1:0] seg_byte(input logic [SEG_W-1:0] seg);
        logic [BYTE_W-1:0] b;
        b = 8'h00;
        if      (seg[0]) b = 8'h2E;
        else if (seg[1]) b = 8'h36;
        else if (seg[2]) b = 8'h3E;
        else if (seg[3]) b = 8'h26;
        else if (seg[4]) b = 8'h64;
        else if (seg[5]) b = 8'h65;
        return b;
    endfunction

    function automatic logic [BYTE_W-1:0] byte_for(input state_t s, input desc_t d);
        logic [BYTE_W-1:0] b;
        b = 8'h00;
        case (s)
            REP:     b = 8'hF3;
            SEG:     b = seg_byte(d.seg);
            OPSZ:    b = 8'h66;
            OPC:     b = d.opcode;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign in_desc = '{rep:    bus.in_is_rep,
                       seg:    bus.in_seg_override,
                       opsz:   bus.in_is_opsize,
                       opcode: bus.in_opcode};

    assign bus.in_ready      = rst_n & ((state_q == IDLE) | ((state_q == OPC) & bus.out_ready));
    assign bus.out_valid     = (state_q != IDLE);
    assign bus.out_byte      = byte_q;
    assign bus.out_last      = last_q;
    assign bus.out_pfx_count = cnt_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign advance = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            desc_q  <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new accept outranks the advance of a finishing opcode handshake.
    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        byte_d  = byte_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (accept) begin
            desc_d  = in_desc;
            state_d = next_state(IDLE, in_desc);
            byte_d  = byte_for(state_d, in_desc);
            last_d  = (state_d == OPC);
            cnt_d   = CNT_W'(in_desc.rep) + CNT_W'(|in_desc.seg) + CNT_W'(in_desc.opsz);
        end else if (advance) begin
            state_d = next_state(state_q, desc_q);
            byte_d  = byte_for(state_d, desc_q);
            last_d  = (state_d == OPC);
        end
    end
endmodule
